// File: rtl/core_wb_stage.sv
// core_wb_stage -- writeback stage of the RV32IMF five-stage pipeline.
//
// Takes the W-side pipeline registers from the memory stage plus the raw
// data-bus read word. It aligns and extends load data and drives the
// register-file write port. Load data that arrives while the pipeline is
// stalled is held until the instruction can retire. The stage also raises
// wb_stall_o while a load's data is still outstanding, and counts retired
// instructions.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   w_regfile_waddr_i     destination register
//   w_regfile_rd_i        ALU/forwarded result
//   w_regfile_wr_i        instruction writes rd
//   w_is_load_store_i     instruction is a load or store
//   w_LOAD_op_i           load funct3 (LB/LH/LW/LBU/LHU)
//   w_addr_lo_i           data address bits [1:0]
//   data_rdata_i          raw data-bus read word
//   data_rvalid_i         read data valid this cycle
//   stall_general_i       global pipeline stall (already includes wb_stall_o)
//   regfile_we_o          register-file write enable
//   regfile_waddr_o       register-file write address
//   regfile_wdata_o       register-file write data
//   wb_stall_o            load in W still waiting for its data
//   spurious_rvalid_o     sticky flag: rvalid seen with no load pending
//   instret_o             retired-instruction count
module core_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int INSTRET_WIDTH  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] w_regfile_waddr_i,
  input  logic [DATA_WIDTH-1:0]     w_regfile_rd_i,
  input  logic                      w_regfile_wr_i,
  input  logic                      w_is_load_store_i,
  input  logic [2:0]                w_LOAD_op_i,
  input  logic [1:0]                w_addr_lo_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_rvalid_i,
  input  logic                      stall_general_i,
  output logic                      regfile_we_o,
  output logic [REG_ADDR_WIDTH-1:0] regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]     regfile_wdata_o,
  output logic                      wb_stall_o,
  output logic                      spurious_rvalid_o,
  output logic [INSTRET_WIDTH-1:0]  instret_o
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     hold_q, hold_d;
  logic [INSTRET_WIDTH-1:0]  instret_q, instret_d;
  logic                      spurious_q, spurious_d;

  logic                      valid;
  logic                      is_load;
  logic                      retire;
  logic [DATA_WIDTH-1:0]     load_word;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;
  logic [DATA_WIDTH-1:0]     load_data;

  // A store has wr=0, so a load is the only load/store that also writes rd.
  assign valid   = w_regfile_wr_i | w_is_load_store_i;
  assign is_load = w_is_load_store_i & w_regfile_wr_i;
  assign retire  = valid & ~stall_general_i;

  // Once data has been captured (HOLD) the load is no longer waiting, even
  // though rvalid has long since dropped.
  assign wb_stall_o = is_load & (state_q != HOLD) & ~data_rvalid_i;

  // Byte lane picked by addr_lo; halfword lane by addr_lo[1] only.
  assign load_word = (state_q == HOLD) ? hold_q : data_rdata_i;
  assign load_byte = load_word[{w_addr_lo_i, 3'b000} +: 8];
  assign load_half = load_word[{w_addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data = load_word;
    case (w_LOAD_op_i)
      3'b000:  load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_data = load_word;
    endcase
  end

  assign regfile_wdata_o = is_load ? load_data : w_regfile_rd_i;
  assign regfile_waddr_o = w_regfile_waddr_i;
  assign regfile_we_o    = retire & w_regfile_wr_i &
                           (w_regfile_waddr_i != '0) & ~wb_stall_o;

  // If rvalid and retire coincide in IDLE, the live word is written straight
  // through and nothing is captured.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    instret_d  = instret_q;
    spurious_d = spurious_q;

    case (state_q)
      IDLE: begin
        if (is_load & data_rvalid_i & stall_general_i) begin
          state_d = HOLD;
          hold_d  = data_rdata_i;
        end
      end
      HOLD: begin
        if (retire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      instret_d = instret_q + INSTRET_WIDTH'(1);
    end

    if (data_rvalid_i & (~is_load | (state_q == HOLD))) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      instret_q  <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      instret_q  <= instret_d;
      spurious_q <= spurious_d;
    end
  end

  assign instret_o         = instret_q;
  assign spurious_rvalid_o = spurious_q;

endmodule

// File: tb/tb_core_wb_stage.sv
// Testbench for core_wb_stage. A driver issues whole instructions (bubble,
// ALU, load, store) with randomized timing, and pushes the register write
// each instruction should produce into a queue. A monitor on the falling
// edge pops and compares whenever the DUT asserts regfile_we_o. It also
// checks wb_stall_o on every cycle.
module tb_core_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 64;

  localparam int K_BUBBLE = 0;
  localparam int K_ALU    = 1;
  localparam int K_LOAD   = 2;
  localparam int K_STORE  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] w_regfile_waddr_i;
  logic [DW-1:0] w_regfile_rd_i;
  logic          w_regfile_wr_i;
  logic          w_is_load_store_i;
  logic [2:0]    w_LOAD_op_i;
  logic [1:0]    w_addr_lo_i;
  logic [DW-1:0] data_rdata_i;
  logic          data_rvalid_i;
  logic          stall_general_i;
  logic          regfile_we_o;
  logic [AW-1:0] regfile_waddr_o;
  logic [DW-1:0] regfile_wdata_o;
  logic          wb_stall_o;
  logic          spurious_rvalid_o;
  logic [IW-1:0] instret_o;

  logic          extStall;
  logic          expWbStall;
  logic          monEn;
  logic [IW-1:0] expInstret;
  logic [AW+DW-1:0] expQ[$];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // The pipeline's global stall already contains this stage's own stall.
  assign stall_general_i = extStall | wb_stall_o;

  core_wb_stage #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(AW),
    .INSTRET_WIDTH (IW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .w_regfile_waddr_i(w_regfile_waddr_i),
    .w_regfile_rd_i   (w_regfile_rd_i),
    .w_regfile_wr_i   (w_regfile_wr_i),
    .w_is_load_store_i(w_is_load_store_i),
    .w_LOAD_op_i      (w_LOAD_op_i),
    .w_addr_lo_i      (w_addr_lo_i),
    .data_rdata_i     (data_rdata_i),
    .data_rvalid_i    (data_rvalid_i),
    .stall_general_i  (stall_general_i),
    .regfile_we_o     (regfile_we_o),
    .regfile_waddr_o  (regfile_waddr_o),
    .regfile_wdata_o  (regfile_wdata_o),
    .wb_stall_o       (wb_stall_o),
    .spurious_rvalid_o(spurious_rvalid_o),
    .instret_o        (instret_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference load extraction, in plain shift/mask arithmetic.
  function automatic logic [31:0] loadExtract(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [31:0] word);
    int unsigned loInt;
    logic [31:0] b;
    logic [31:0] h;
    loInt = lo;
    b = (word >> (loInt * 8)) & 32'h0000_00FF;
    h = (word >> ((loInt / 2) * 16)) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("wb_stall", {63'd0, wb_stall_o}, {63'd0, expWbStall});
      if (regfile_we_o === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_write: got waddr=%0d wdata=0x%0h expected no write",
                   regfile_waddr_o, regfile_wdata_o);
        end else begin
          checkOutput("rf_write", {27'd0, regfile_waddr_o, regfile_wdata_o},
                      {27'd0, expQ.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBubble();
    w_regfile_wr_i    = 1'b0;
    w_is_load_store_i = 1'b0;
    data_rvalid_i     = 1'b0;
    extStall          = 1'b0;
    expWbStall        = 1'b0;
  endtask

  // One instruction from entry into W until it retires. delay = cycles
  // before rvalid, k = stall cycles after the data (or before an ALU/store retires).
  task automatic applyStimulus(input int kind, input logic [AW-1:0] wa,
                               input logic [31:0] rd, input logic [2:0] f3,
                               input logic [1:0] lo, input logic [31:0] word,
                               input int delay, input int k,
                               input logic [31:0] expData, input bit holdZero);
    if (kind != K_BUBBLE) expInstret = expInstret + 64'd1;
    if ((kind == K_ALU || kind == K_LOAD) && wa != '0) expQ.push_back({wa, expData});
    w_regfile_waddr_i = wa;
    w_regfile_rd_i    = rd;
    w_regfile_wr_i    = (kind == K_ALU || kind == K_LOAD);
    w_is_load_store_i = (kind == K_LOAD || kind == K_STORE);
    w_LOAD_op_i       = f3;
    w_addr_lo_i       = lo;
    data_rvalid_i     = 1'b0;
    if (kind == K_LOAD) begin
      for (int i = 0; i < delay; i++) begin
        data_rdata_i = $urandom;
        extStall     = 1'($urandom_range(0, 1));
        expWbStall   = 1'b1;
        tick();
      end
      data_rvalid_i = 1'b1;
      data_rdata_i  = word;
      extStall      = (k > 0);
      expWbStall    = 1'b0;
      tick();
      for (int i = 1; i <= k; i++) begin
        data_rvalid_i = 1'b0;
        data_rdata_i  = holdZero ? 32'd0 : $urandom;
        extStall      = (i < k);
        expWbStall    = 1'b0;
        tick();
      end
      data_rvalid_i = 1'b0;
    end else begin
      for (int i = 0; i <= k; i++) begin
        data_rdata_i = $urandom;
        extStall     = (i < k);
        expWbStall   = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    monEn             = 1'b0;
    rst_n             = 1'b0;
    w_regfile_waddr_i = '0;
    w_regfile_rd_i    = '0;
    w_LOAD_op_i       = '0;
    w_addr_lo_i       = '0;
    data_rdata_i      = '0;
    driveBubble();
    expInstret = '0;
    #12;
    checkOutput("reset_we", {63'd0, regfile_we_o}, 64'd0);
    checkOutput("reset_wb_stall", {63'd0, wb_stall_o}, 64'd0);
    checkOutput("reset_instret", instret_o, 64'd0);
    checkOutput("reset_spurious", {63'd0, spurious_rvalid_o}, 64'd0);
    tick();
    rst_n = 1'b1;
    monEn = 1'b1;
    tick();

    // Directed cases with literal expectations.
    applyStimulus(K_ALU,  5'd5, 32'h1234, 3'd0, 2'd0, 32'h0, 0, 0, 32'h0000_1234, 0);
    applyStimulus(K_BUBBLE, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    checkOutput("instret_after_alu", instret_o, 64'd1);
    tick();
    applyStimulus(K_LOAD, 5'd6, 32'h0, 3'b000, 2'd2, 32'h0080_0000, 0, 0, 32'hFFFF_FF80, 0);
    applyStimulus(K_LOAD, 5'd7, 32'h0, 3'b100, 2'd2, 32'h0080_0000, 0, 0, 32'h0000_0080, 0);
    applyStimulus(K_LOAD, 5'd8, 32'h0, 3'b001, 2'd3, 32'hBEEF_1234, 0, 0, 32'hFFFF_BEEF, 0);
    applyStimulus(K_LOAD, 5'd9, 32'h0, 3'b101, 2'd3, 32'hBEEF_1234, 0, 0, 32'h0000_BEEF, 0);
    applyStimulus(K_LOAD, 5'd10, 32'h0, 3'b010, 2'd1, 32'hBEEF_1234, 0, 0, 32'hBEEF_1234, 0);
    applyStimulus(K_LOAD, 5'd11, 32'h0, 3'b010, 2'd0, 32'h1357_9BDF, 3, 0, 32'h1357_9BDF, 0);
    applyStimulus(K_LOAD, 5'd12, 32'h0, 3'b010, 2'd0, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D, 1);
    applyStimulus(K_ALU,  5'd0, 32'hDEAD, 3'd0, 2'd0, 32'h0, 0, 0, 32'h0, 0);
    applyStimulus(K_STORE, 5'd3, 32'h55, 3'd2, 2'd0, 32'h0, 0, 1, 32'h0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      int kind;
      logic [AW-1:0] wa;
      logic [31:0] rd, word;
      logic [2:0] f3;
      logic [1:0] lo;
      kind = $urandom_range(0, 3);
      wa   = AW'($urandom);
      rd   = $urandom;
      word = $urandom;
      f3   = 3'($urandom_range(0, 7));
      lo   = 2'($urandom);
      if (kind == K_LOAD)
        applyStimulus(kind, wa, rd, f3, lo, word, $urandom_range(0, 3),
                      $urandom_range(0, 3), loadExtract(f3, lo, word), 0);
      else
        applyStimulus(kind, wa, rd, f3, lo, word, 0, $urandom_range(0, 2), rd, 0);
    end

    driveBubble();
    tick();
    @(negedge clk);
    checkOutput("instret_total", instret_o, expInstret);
    checkOutput("spurious_clean", {63'd0, spurious_rvalid_o}, 64'd0);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    tick();

    // rvalid during a bubble is spurious and sticks.
    data_rvalid_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("spurious_set", {63'd0, spurious_rvalid_o}, 64'd1);
    tick();
    tick();
    checkOutput("spurious_sticky", {63'd0, spurious_rvalid_o}, 64'd1);

    // Capture a load into HOLD, then reset before it retires: no write.
    w_regfile_waddr_i = 5'd15;
    w_regfile_wr_i    = 1'b1;
    w_is_load_store_i = 1'b1;
    w_LOAD_op_i       = 3'b010;
    data_rdata_i      = 32'hA5A5_5A5A;
    data_rvalid_i     = 1'b1;
    extStall          = 1'b1;
    expWbStall        = 1'b0;
    tick();
    data_rvalid_i = 1'b0;
    tick();
    driveBubble();
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_instret", instret_o, 64'd0);
    checkOutput("midreset_spurious", {63'd0, spurious_rvalid_o}, 64'd0);
    tick();
    rst_n = 1'b1;
    expInstret = '0;
    tick();
    tick();
    tick();
    @(negedge clk);
    checkOutput("midreset_no_write", 64'(expQ.size()), 64'd0);
    checkOutput("midreset_instret_after", instret_o, 64'd0);

    monEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
